// File: rtl/uc_secuenciador.sv
// Sequencing control unit: decodes Opcode/z into datapath controls and adds
// run/halt/single-step sequencing plus a multi-cycle WAIT instruction.
module uc_secuenciador #(
  parameter bit AUTO_START = 1'b0
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic       z,
  input  logic       start,
  input  logic       step_mode,
  input  logic       step,
  output logic       s_inc,
  output logic       s_inm,
  output logic       we3,
  output logic       wez,
  output logic [2:0] Op,
  output logic       pc_en,
  output logic       running,
  output logic       halted,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_WAIT = 2'd2,
    S_HALT = 2'd3
  } state_t;

  state_t     state, state_next;
  logic [2:0] cnt, cnt_next;
  logic       step_q;
  logic       step_rise;
  logic       commit;

  // Pure instruction decode, only applied to the outputs on a commit.
  logic       dec_s_inc, dec_s_inm, dec_we3, dec_wez;
  logic [2:0] dec_op;
  logic       is_wait, is_halt;

  assign step_rise = step & ~step_q;
  assign commit    = ~step_mode | step_rise;
  assign is_wait   = (Opcode[5:3] == 3'b001);
  assign is_halt   = (Opcode == 6'b000111);

  always_comb begin
    dec_s_inc = 1'b1;
    dec_s_inm = 1'b0;
    dec_we3   = 1'b0;
    dec_wez   = 1'b0;
    dec_op    = 3'b000;
    if (Opcode[5]) begin
      dec_op  = Opcode[4:2];
      dec_we3 = 1'b1;
      dec_wez = 1'b1;
    end else begin
      case (Opcode)
        6'b000000: begin
          dec_s_inm = 1'b1;
          dec_we3   = 1'b1;
        end
        6'b000100: dec_s_inc = 1'b0;
        6'b000101: dec_s_inc = ~z;
        6'b000110: dec_s_inc = z;
        default:   dec_s_inc = 1'b1;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state  <= S_IDLE;
      cnt    <= 3'd0;
      step_q <= 1'b0;
    end else begin
      state  <= state_next;
      cnt    <= cnt_next;
      step_q <= step;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    s_inc      = 1'b1;
    s_inm      = 1'b0;
    we3        = 1'b0;
    wez        = 1'b0;
    Op         = 3'b000;
    pc_en      = 1'b0;
    case (state)
      S_IDLE: begin
        if (AUTO_START || start) state_next = S_RUN;
      end
      S_RUN: begin
        if (commit) begin
          if (is_wait) begin
            cnt_next   = Opcode[2:0];
            state_next = S_WAIT;
          end else if (is_halt) begin
            state_next = S_HALT;
          end else begin
            s_inc = dec_s_inc;
            s_inm = dec_s_inm;
            we3   = dec_we3;
            wez   = dec_wez;
            Op    = dec_op;
            pc_en = 1'b1;
          end
        end
      end
      S_WAIT: begin
        // Counter drains to zero first; the PC advances on the cycle it reads zero.
        if (cnt != 3'd0) begin
          cnt_next = cnt - 3'd1;
        end else begin
          pc_en      = 1'b1;
          state_next = S_RUN;
        end
      end
      S_HALT: state_next = S_HALT;
      default: state_next = S_IDLE;
    endcase
  end

  assign running   = (state == S_RUN) || (state == S_WAIT);
  assign halted    = (state == S_HALT);
  assign state_dbg = state;

endmodule

// File: doc/uc_secuenciador.md
# uc_secuenciador

Sequencing control unit for the single-cycle microcontroller datapath (PC, program memory, register bank, ALU, zero flag). It decodes the 6-bit `Opcode` and the registered zero flag `z` into the datapath controls `s_inc`, `s_inm`, `we3`, `wez` and `Op`. It adds run/halt/single-step sequencing and a multi-cycle `WAIT` instruction, and exposes `pc_en` to the PC register's enable in the revised top level.

## Interface
- `AUTO_START`, default 0: if 1, the FSM leaves IDLE on the first clock after reset without waiting for `start`.
- `clk` input, 1 bit: single clock, rising edge.
- `reset` input, 1 bit: asynchronous, active-low. 0 forces the reset state immediately.
- `Opcode` input, 6 bits: instruction[15:10] from program memory.
- `z` input, 1 bit: zero-flag register output.
- `start` input, 1 bit: level. Leaves IDLE when sampled 1.
- `step_mode` input, 1 bit: 1 selects single-step execution.
- `step` input, 1 bit: step request. Only its rising edge counts.
- `s_inc` output, 1 bit: 1 selects PC+1, 0 selects the jump target.
- `s_inm` output, 1 bit: 1 writes the immediate to the register bank, 0 writes the ALU result.
- `we3` output, 1 bit: register bank write enable.
- `wez` output, 1 bit: zero-flag write enable.
- `Op` output, 3 bits: ALU operation.
- `pc_en` output, 1 bit: PC load enable.
- `running` output, 1 bit: FSM is in RUN or WAIT.
- `halted` output, 1 bit: FSM is in HALT.

## Operation
- Decode:
  - `Opcode[5]=1` is ALU: `Op=Opcode[4:2]`, `we3=1`, `wez=1`, `s_inm=0`, `s_inc=1`.
  - `000000` is LI: `s_inm=1`, `we3=1`, `wez=0`, `s_inc=1`.
  - `000100` is J: `s_inc=0`.
  - `000101` is JZ: `s_inc=~z`.
  - `000110` is JNZ: `s_inc=z`.
  - `000111` is HALT.
  - `001kkk` is WAIT k.
  - All other codes are NOP: `s_inc=1`, no writes.
- Commit condition: in RUN, `commit = ~step_mode | step_rise`, where `step_rise = step & ~step_q` and `step_q` is `step` registered every cycle.
- Outputs are decode values only when committing a non-WAIT, non-HALT instruction, and `pc_en=1` in that cycle.
- Otherwise the defaults apply: `s_inc=1`, `s_inm=0`, `Op=000`, `we3=0`, `wez=0`, `pc_en=0`.
- FSM states:
  - IDLE: goes to RUN when `start=1`, or unconditionally if `AUTO_START=1`.
  - RUN: commits one instruction per committing cycle. A committed WAIT loads `cnt<=kkk` (3-bit counter) and goes to WAIT, with `pc_en=0` that cycle. A committed HALT goes to HALT with `pc_en=0`.
  - WAIT: ignores `step`/`step_mode`. If `cnt!=0`, `cnt<=cnt-1` and `pc_en=0`. If `cnt==0`, `pc_en=1` with `s_inc=1`, then back to RUN.
  - HALT: terminal. Only `reset` exits it. `start` and `step` are ignored.
- `running=1` in RUN/WAIT. `halted=1` in HALT.

## Timing
- Reset values: state IDLE, `cnt=0`, `step_q=0`, `s_inc=1`, `s_inm=0`, `Op=000`, `we3=0`, `wez=0`, `pc_en=0`, `running=0`, `halted=0`.
- Decode is combinational within the cycle. State, `cnt` and `step_q` are registered.
- Normal instructions: 1 cycle. Datapath writes and PC update happen at the same rising edge.
- WAIT k: k+2 cycles from issue to PC advance; PC increments at the edge ending WAIT with `cnt==0`.
- JZ/JNZ use `z` as sampled in the same cycle, i.e. the flag written by the previous committed ALU instruction.
- Step-mode boundaries:
  - `step` held high commits exactly one instruction.
  - `step` rising on the same cycle that `step_mode` drops gives one commit in that cycle.
- A `start` pulse shorter than one cycle that misses the rising edge is lost. `start` is a level.
- Reset asserted mid-WAIT or mid-step: immediate IDLE and all enables 0. No partial write occurs after reset deasserts.

## Test plan
- Reset release with `AUTO_START=0`, `start=0` for 5 cycles -> `pc_en=0`, `we3=0`, `running=0` throughout. `start=1` -> `running=1` next cycle.
- `Opcode=101100` (ALU, Op=011) in RUN -> same cycle `Op=011`, `we3=1`, `wez=1`, `s_inm=0`, `pc_en=1`. Then `000000` -> `s_inm=1`, `we3=1`, `wez=0`.
- JZ (`000101`) with `z=1` -> `s_inc=0`, `pc_en=1`. With `z=0` -> `s_inc=1`. JNZ with `z=0` -> `s_inc=0`.
- WAIT 3 (`001011`) -> `pc_en` pattern 0,0,0,0,1 over 5 cycles, `running=1` throughout. WAIT 0 -> pattern 0,1.
- `step_mode=1`, `step` high for 4 cycles then low 2, then high again -> exactly 2 commits (`pc_en=1` twice). Reset (`reset=0`) mid-WAIT -> `pc_en=0`, `running=0` immediately.
- HALT (`000111`) -> `halted=1` next cycle, `pc_en=0` for 10 cycles despite `start=1` and `step` toggling. `reset` low then high -> IDLE, `halted=0`.
